// File: rtl/fs_serial_4bit_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The slave side is the subtractor; the master side feeds operands and takes results.
interface fs_serial_4bit_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output in_valid, in1, in2, borrow_in, out_ready,
        input  in_ready, out_valid, diff, borrow_out
    );

    modport slave (
        input  in_valid, in1, in2, borrow_in, out_ready,
        output in_ready, out_valid, diff, borrow_out
    );
endinterface

// File: rtl/fs_serial_4bit.sv
// Bit-serial subtractor: {borrow_out, diff} = in1 - in2 - borrow_in, one bit per clock,
// LSB first, through a single 1-bit full-subtractor cell.
module fs_serial_4bit #(
    parameter int unsigned WIDTH = 4
) (
    input logic           clk,
    input logic           rst_n,
    fs_serial_4bit_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic cell_a, cell_b, cell_d, cell_br;

    // One full-subtractor cell working on the current LSB of the operand shifters.
    always_comb begin
        cell_a  = a_q[0];
        cell_b  = b_q[0];
        cell_d  = cell_a ^ cell_b ^ br_q;
        cell_br = (~cell_a & cell_b) | (~(cell_a ^ cell_b) & br_q);
    end

    // Next-state: latch operands in idle, shift one bit per cycle, hold the result until taken.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.in1;
                    b_d     = bus.in2;
                    br_d    = bus.borrow_in;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                a_d              = a_q >> 1;
                b_d              = b_q >> 1;
                br_d             = cell_br;
                // Result enters at the MSB so bit i lands at diff[i] after WIDTH shifts.
                diff_d           = diff_q >> 1;
                diff_d[WIDTH-1]  = cell_d;
                cnt_d            = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    borrow_d = cell_br;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; synchronous active-low reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    // Handshake outputs; in_ready is masked while reset is held.
    always_comb begin
        bus.in_ready   = rst_n && (state_q == StIdle);
        bus.out_valid  = (state_q == StDone);
        bus.diff       = diff_q;
        bus.borrow_out = borrow_q;
    end
endmodule

// File: tb/tb_fs_serial_4bit.sv
// Randomised and directed checks of the bit-serial subtractor against an arithmetic model.
module tb_fs_serial_4bit;
    localparam int unsigned W = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   cyc;

    fs_serial_4bit_if #(.WIDTH(W)) bus ();

    fs_serial_4bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer subtraction of the operands.
    function automatic logic [W-1:0] ref_diff(input int a, input int b, input int c);
        int r;
        r = a - b - c;
        if (r < 0) r += (1 << W);
        return W'(r);
    endfunction

    function automatic logic ref_borrow(input int a, input int b, input int c);
        return (a < b + c);
    endfunction

    // Run one operation from a negedge; returns the cycle number just before the accept edge.
    // stall = cycles out_ready is held low once out_valid is seen; side_op drives a competing
    // in_valid request (7-8-0) during the stall.
    task automatic run_op(input int a, input int b, input int c, input int stall,
                          input bit side_op, output int acc_cyc);
        int k;
        logic [W-1:0] exp_d;
        logic         exp_b;
        exp_d = ref_diff(a, b, c);
        exp_b = ref_borrow(a, b, c);
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_eq("in_ready_before_op", 32'(bus.in_ready), 32'd1);
        bus.out_ready = (stall == 0);
        bus.in_valid  = 1'b1;
        bus.in1       = W'(a);
        bus.in2       = W'(b);
        bus.borrow_in = c[0];
        acc_cyc = cyc;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in1       = W'($urandom);
        bus.in2       = W'($urandom);
        bus.borrow_in = 1'($urandom);
        k = 0;
        while (!bus.out_valid && k < 20) begin
            check_eq("in_ready_busy", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
            k++;
        end
        check_eq("latency", 32'(k), 32'(W));
        check_eq("diff", 32'(bus.diff), 32'(exp_d));
        check_eq("borrow_out", 32'(bus.borrow_out), 32'(exp_b));
        if (side_op) begin
            bus.in_valid = 1'b1;
            bus.in1 = 4'd7;
            bus.in2 = 4'd8;
            bus.borrow_in = 1'b0;
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_eq("stall_valid", 32'(bus.out_valid), 32'd1);
            check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check_eq("stall_diff", 32'(bus.diff), 32'(exp_d));
            check_eq("stall_borrow", 32'(bus.borrow_out), 32'(exp_b));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq("valid_cleared", 32'(bus.out_valid), 32'd0);
        check_eq("ready_after_hs", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int acc;
        int prev;
        int a;
        int b;
        int c;
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.borrow_in = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_diff", 32'(bus.diff), 32'd0);
        check_eq("rst_borrow", 32'(bus.borrow_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Directed cases
        run_op(9, 2, 1, 0, 1'b0, acc);
        run_op(0, 0, 1, 0, 1'b0, acc);
        run_op(2, 13, 0, 0, 1'b0, acc);
        run_op(15, 15, 1, 0, 1'b0, acc);
        run_op(15, 15, 0, 0, 1'b0, acc);

        // Backpressure with a competing request, which is then accepted
        run_op(5, 12, 1, 3, 1'b1, acc);
        run_op(7, 8, 0, 0, 1'b0, acc);

        // Reset during bit 2 of 14-11-1
        bus.in_valid  = 1'b1;
        bus.in1       = 4'd14;
        bus.in2       = 4'd11;
        bus.borrow_in = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midrst_diff", 32'(bus.diff), 32'd0);
        check_eq("midrst_borrow", 32'(bus.borrow_out), 32'd0);
        check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_ready_after", 32'(bus.in_ready), 32'd1);
        run_op(14, 1, 0, 0, 1'b0, acc);

        // Exhaustive sweep, back-to-back
        prev = 0;
        for (int i = 0; i < 512; i++) begin
            run_op(i >> 5, (i >> 1) & 15, i & 1, 0, 1'b0, acc);
            if (i > 0) check_eq("accept_spacing", 32'(acc - prev), 32'(W + 2));
            prev = acc;
        end

        // Random operands with random backpressure
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(15, 0));
            b = int'($urandom_range(15, 0));
            c = int'($urandom_range(1, 0));
            run_op(a, b, c, int'($urandom_range(3, 0)), 1'b0, acc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
